rca_seq_ctrl: RTL and testbench
===============================

Name: rca_seq_ctrl

Overview:
- Multi-precision add/subtract sequencer. It time-shares one 8-bit ripple-carry slice (an internal rca_behavioral instance, ports a, b, cin, sum, cout) to process WORDS*8-bit operands, one byte per clock, LSB slice first.
- Carry is chained between slices in a register.
- Start/busy/done handshake; used where a wide adder would cost too much area.

Parameters:
- W, 8, slice width; must match the adder instance.
- WORDS, 4, number of slices; operand width is W*WORDS.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- start  input  1  request; sampled only in IDLE or DONE
- sub  input  1  0 = a+b+cin, 1 = a-b (cin ignored)
- cin  input  1  carry-in for add mode
- a  input  W*WORDS  operand A, sampled with start
- b  input  W*WORDS  operand B, sampled with start
- busy  output  1  high while slices are being processed
- done  output  1  one-cycle pulse; results valid
- sum  output  W*WORDS  result
- cout  output  1  final carry-out (sub: 1 = no borrow)
- ovf  output  1  signed two's-complement overflow

Behaviour:
- Clock, reset and state:
  - Single clock domain; all state updates on rising clk edge.
  - Reset is synchronous and active-high; it takes effect only at a clock edge with rst=1.
  - States are IDLE, RUN and DONE. Internal registers: a_r, b_r, carry, idx (clog2(WORDS) bits), sum.
- Reset:
  - State goes to IDLE; idx=0, carry=0.
  - Outputs: busy=0, done=0, sum=0, cout=0, ovf=0.
  - Reset overrides start and aborts RUN mid-operation; no done pulse is issued for the aborted operation.
- IDLE or DONE with start=1:
  - Latch a_r=a.
  - Latch b_r=b when sub=0, b_r=~b when sub=1.
  - carry = sub ? 1 : cin.
  - idx=0; go to RUN; busy=1 from the next cycle.
  - sum, cout and ovf are not cleared at start; they keep the previous result until overwritten slice by slice.
- IDLE with start=0: hold.
- DONE with start=0: go to IDLE; done falls.
- RUN, per cycle:
  - The adder is fed a_r[idx*W +: W], b_r[idx*W +: W] and carry.
  - At the edge: sum[idx*W +: W] is written with the adder sum, carry is written with the adder cout, and idx increments.
- RUN, when idx==WORDS-1 at the edge:
  - cout = adder cout.
  - ovf = (a_r MSB == b_r MSB) && (new sum MSB != a_r MSB).
  - Go to DONE.
- DONE:
  - done=1 and busy=0 for exactly one cycle.
  - sum, cout and ovf are stable from the DONE cycle until the next start is accepted.
- Latency:
  - start sampled at edge 0; slices written at edges 1..WORDS.
  - done is high in the cycle after edge WORDS, i.e. WORDS+1 cycles after start.
- Back-to-back: start=1 during DONE is accepted and RUN restarts on the next edge, giving a throughput of one operation per WORDS+1 cycles.
- start during RUN is ignored, with no queueing, and the in-flight operands are unaffected.
- Operand inputs a, b, sub and cin may change freely after the start edge.
- idx never exceeds WORDS-1; no wrap occurs beyond it.
- No combinational path exists from any input to any output.

Test Plan:
- Reset: rst=1 for 2 cycles with start=1 held -> busy=0, done=0, sum=0, cout=0, ovf=0.
- Add with ripple:
  - a=0x000000FF, b=0x00000001, cin=0, sub=0 -> sum=0x00000100, cout=0, ovf=0.
  - done is a single-cycle pulse exactly 5 cycles after the start edge; busy is high for exactly 4 cycles.
- Full carry: a=0xFFFFFFFF, b=0x00000001, cin=0 -> sum=0x00000000, cout=1, ovf=0. Then a=0xAAAAAAAA, b=0x55555555, cin=1 -> sum=0x00000000, cout=1.
- Subtract and overflow:
  - sub=1, a=5, b=7 -> sum=0xFFFFFFFE, cout=0, ovf=0.
  - sub=0, a=0x7FFFFFFF, b=1 -> sum=0x80000000, ovf=1.
  - sub=1, a=0x80000000, b=1 -> sum=0x7FFFFFFF, ovf=1, cout=1.
- Handshake:
  - A start pulse in each RUN cycle is ignored (result unchanged; exactly one done).
  - start held high through DONE produces a back-to-back second operation, with done pulses 5 cycles apart.
- Reset mid-operation: rst=1 at the 2nd RUN cycle -> IDLE with busy=0, sum=0, and no done pulse. A subsequent a=0x01010101, b=0x01010101 add -> 0x02020202.

Source files
------------

// File: rtl/rca_seq_ctrl.sv
// Multi-precision add/subtract sequencer.
// One W-bit ripple-carry slice is time-shared to add or subtract W*WORDS-bit
// operands, one slice per clock, least significant slice first. The carry
// between slices is kept in a register; a start/busy/done handshake frames
// each operation.

// Plain W-bit ripple-carry adder slice.
module rca_behavioral #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  // Full W-bit add with carry-in; the extra top bit is the carry-out.
  assign {cout, sum} = a + b + cin;

endmodule

module rca_seq_ctrl #(
  parameter int W     = 8,
  parameter int WORDS = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               sub,
  input  logic               cin,
  input  logic [W*WORDS-1:0] a,
  input  logic [W*WORDS-1:0] b,
  output logic               busy,
  output logic               done,
  output logic [W*WORDS-1:0] sum,
  output logic               cout,
  output logic               ovf
);

  localparam int N  = W * WORDS;
  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t          r_state;
  logic [N-1:0]    r_a;
  logic [N-1:0]    r_b;
  logic            r_carry;
  logic [IW-1:0]   r_idx;
  logic [N-1:0]    r_sum;
  logic            r_cout;
  logic            r_ovf;
  logic            r_busy;
  logic            r_done;

  logic [W-1:0]    w_a_slice;
  logic [W-1:0]    w_b_slice;
  logic [W-1:0]    w_sum_slice;
  logic            w_cout_slice;
  logic            w_last;

  // Select the current slice of the latched operands.
  assign w_a_slice = r_a[r_idx*W +: W];
  assign w_b_slice = r_b[r_idx*W +: W];
  assign w_last    = (r_idx == IW'(WORDS - 1));

  rca_behavioral #(.W(W)) u_slice (
    .a    (w_a_slice),
    .b    (w_b_slice),
    .cin  (r_carry),
    .sum  (w_sum_slice),
    .cout (w_cout_slice)
  );

  // Sequencer FSM: latch operands on start, walk the slices, pulse done.
  // NOTE: every register here is assigned with <= so all updates in this
  // block see the pre-edge values, exactly like the flops they become.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_idx   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            // Subtraction is a + ~b + 1: invert B and force the carry-in.
            r_a     <= a;
            r_b     <= sub ? ~b : b;
            r_carry <= sub ? 1'b1 : cin;
            r_idx   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_RUN;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_RUN: begin
          r_sum[r_idx*W +: W] <= w_sum_slice;
          r_carry             <= w_cout_slice;
          if (w_last) begin
            // Overflow: operand signs agree but the result sign differs.
            r_cout  <= w_cout_slice;
            r_ovf   <= (r_a[N-1] == r_b[N-1]) && (w_sum_slice[W-1] != r_a[N-1]);
            r_idx   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_idx <= r_idx + IW'(1);
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign sum  = r_sum;
  assign cout = r_cout;
  assign ovf  = r_ovf;

endmodule

// File: tb/tb_rca_seq_ctrl.sv
// Testbench for rca_seq_ctrl: directed vector table, handshake corner cases
// and randomized operations compared against an arithmetic reference model.
module tb_rca_seq_ctrl;

  localparam int W     = 8;
  localparam int WORDS = 4;
  localparam int N     = W * WORDS;
  localparam int LAT   = WORDS + 1;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         sub;
  logic         cin;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         busy;
  logic         done;
  logic [N-1:0] sum;
  logic         cout;
  logic         ovf;

  int n_total = 0;
  int n_pass  = 0;

  rca_seq_ctrl #(.W(W), .WORDS(WORDS)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .sub   (sub),
    .cin   (cin),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         sub;
    logic         cin;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] sum;
    logic         cout;
    logic         ovf;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Advance one clock and sample 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: the mathematical result of a+b+cin or a-b on N-bit words.
  task automatic model(input logic s, input logic c, input logic [N-1:0] av,
                       input logic [N-1:0] bv, output logic [N-1:0] es,
                       output logic ec, output logic eo);
    longint ua, ub, sa, sb, ures, sres;
    ua = longint'({32'd0, av});
    ub = longint'({32'd0, bv});
    sa = longint'($signed(av));
    sb = longint'($signed(bv));
    if (s) begin
      ures = ua - ub;
      sres = sa - sb;
      ec   = (ua >= ub);
    end else begin
      ures = ua + ub + longint'(c);
      sres = sa + sb + longint'(c);
      ec   = (ures >= (64'sd1 <<< N));
    end
    es = ures[N-1:0];
    eo = (sres > ((64'sd1 <<< (N-1)) - 1)) || (sres < -(64'sd1 <<< (N-1)));
  endtask

  // Issue one operation, scramble inputs after the start edge, and wait for done.
  task automatic run_op(input logic s, input logic c, input logic [N-1:0] av,
                        input logic [N-1:0] bv, output int lat, output int busy_cnt,
                        output bit timeout);
    start = 1'b1; sub = s; cin = c; a = av; b = bv;
    tick();
    lat      = 1;
    busy_cnt = busy ? 1 : 0;
    start = 1'b0; a = $urandom; b = $urandom; sub = 1'($urandom); cin = 1'($urandom);
    timeout = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (done) begin
        timeout = 1'b0;
        break;
      end
      tick();
      lat++;
      if (busy) busy_cnt++;
    end
  endtask

  initial begin
    logic [N-1:0] es;
    logic         ec, eo;
    int           lat, bcnt, dcnt, d1, d2;
    bit           to;

    vecs[0] = '{1'b0, 1'b0, 32'h000000FF, 32'h00000001, 32'h00000100, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 1'b0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 32'hAAAAAAAA, 32'h55555555, 32'h00000000, 1'b1, 1'b0};
    vecs[3] = '{1'b1, 1'b0, 32'h00000005, 32'h00000007, 32'hFFFFFFFE, 1'b0, 1'b0};
    vecs[4] = '{1'b0, 1'b0, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1};
    vecs[5] = '{1'b1, 1'b0, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b1, 1'b1};

    // Reset with start held high.
    rst = 1'b1; start = 1'b1; sub = 1'b0; cin = 1'b1; a = '1; b = '1;
    tick();
    tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sum",  sum,  0);
    check("rst_cout", cout, 0);
    check("rst_ovf",  ovf,  0);
    rst = 1'b0; start = 1'b0;
    tick();
    check("idle_busy", busy, 0);

    // Directed vector table.
    foreach (vecs[i]) begin
      run_op(vecs[i].sub, vecs[i].cin, vecs[i].a, vecs[i].b, lat, bcnt, to);
      check($sformatf("vec%0d_timeout", i), to, 0);
      check($sformatf("vec%0d_latency", i), lat, LAT);
      check($sformatf("vec%0d_busy_cycles", i), bcnt, WORDS);
      check($sformatf("vec%0d_busy_at_done", i), busy, 0);
      check($sformatf("vec%0d_sum", i), sum, vecs[i].sum);
      check($sformatf("vec%0d_cout", i), cout, vecs[i].cout);
      check($sformatf("vec%0d_ovf", i), ovf, vecs[i].ovf);
      tick();
      check($sformatf("vec%0d_done_pulse", i), done, 0);
      check($sformatf("vec%0d_sum_hold", i), sum, vecs[i].sum);
    end

    // Start pulses in every RUN cycle are ignored.
    start = 1'b1; sub = 1'b0; cin = 1'b0; a = 32'h12345678; b = 32'h11111111;
    tick();
    dcnt = 0;
    for (int i = 0; i < WORDS; i++) begin
      start = 1'b1; a = $urandom; b = $urandom; sub = 1'($urandom);
      tick();
      if (done) dcnt++;
    end
    start = 1'b0;
    check("ign_done_at_end", done, 1);
    check("ign_sum", sum, 32'h23456789);
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done) dcnt++;
    end
    check("ign_done_count", dcnt, 1);
    check("ign_busy_after", busy, 0);

    // start held through DONE: back-to-back operations.
    start = 1'b1; sub = 1'b0; cin = 1'b0; a = 32'h00000010; b = 32'h00000020;
    tick();
    a = 32'h00001000; b = 32'h00000001; sub = 1'b1;
    d1 = -1; d2 = -1;
    for (int i = 2; i <= 20; i++) begin
      tick();
      if (done) begin
        if (d1 < 0) begin
          d1 = i;
          check("b2b_first_sum", sum, 32'h00000030);
        end else begin
          d2 = i;
          check("b2b_second_sum", sum, 32'h00000FFF);
          check("b2b_second_cout", cout, 1);
          start = 1'b0;
          break;
        end
      end
    end
    start = 1'b0;
    check("b2b_first_latency", d1, LAT);
    check("b2b_spacing", d2 - d1, LAT);
    tick();
    tick();
    check("b2b_idle", busy | done, 0);

    // Reset during the second RUN cycle aborts the operation.
    start = 1'b1; sub = 1'b0; cin = 1'b0; a = 32'h11111111; b = 32'h22222222;
    tick();
    start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_sum",  sum,  0);
    check("abort_done", done, 0);
    dcnt = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done || busy) dcnt++;
    end
    check("abort_no_activity", dcnt, 0);
    run_op(1'b0, 1'b0, 32'h01010101, 32'h01010101, lat, bcnt, to);
    check("post_abort_timeout", to, 0);
    check("post_abort_sum", sum, 32'h02020202);
    tick();

    // Randomized operations against the reference model.
    for (int i = 0; i < 40; i++) begin
      logic [N-1:0] ra, rb;
      logic         rs, rc;
      ra = $urandom; rb = $urandom; rs = 1'($urandom); rc = 1'($urandom);
      if (i % 8 == 0) ra = 32'h7FFFFFFF;
      if (i % 8 == 1) rb = 32'h80000000;
      model(rs, rc, ra, rb, es, ec, eo);
      run_op(rs, rc, ra, rb, lat, bcnt, to);
      check($sformatf("rnd%0d_timeout", i), to, 0);
      check($sformatf("rnd%0d_latency", i), lat, LAT);
      check($sformatf("rnd%0d_sum", i), sum, es);
      check($sformatf("rnd%0d_cout", i), cout, ec);
      check($sformatf("rnd%0d_ovf", i), ovf, eo);
      if (i % 2 == 0) tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
